// File: rtl/rnd_vec_gen_mc.sv
// Lagged-Fibonacci random vector generator with seeded warm-up, multiple
// save/restore checkpoints, additive/XOR recurrence and a ready/err handshake.
module rnd_vec_gen_mc #(
  parameter int OUT_SIZE      = 16,
  parameter int LFSR_LENGTH   = 55,
  parameter int LFSR_FEEDBACK = 24,
  parameter int SLOT_W        = 1,
  parameter int WARMUP        = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init,
  input  logic [OUT_SIZE-1:0] seed,
  input  logic                mode,
  input  logic                next,
  input  logic                save,
  input  logic                restore,
  input  logic [SLOT_W-1:0]   slot,
  output logic [OUT_SIZE-1:0] out,
  output logic                ready,
  output logic                err
);

  localparam int NUM_SLOTS = 2 ** SLOT_W;
  localparam int CNT_W     = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  typedef enum logic [1:0] {IDLE, WARM, READY} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      init_q;
  logic                      err_q, err_d;
  logic [NUM_SLOTS-1:0]      v_q, v_d;
  logic [OUT_SIZE-1:0]       s_q [LFSR_LENGTH];
  logic [OUT_SIZE-1:0]       s_d [LFSR_LENGTH];
  logic [OUT_SIZE-1:0]       c_q [NUM_SLOTS][LFSR_LENGTH];
  logic [OUT_SIZE-1:0]       s_step [LFSR_LENGTH];
  logic [OUT_SIZE-1:0]       fb;
  logic                      lsb_any, word_any;
  logic                      init_rise, cmd, save_en;

  assign init_rise = init & ~init_q;
  assign cmd       = next | save | restore;

  // Feedback word; the guard looks at pre-step state to keep the
  // recurrence out of its all-even (add) or all-zero (xor) fixed point.
  always_comb begin
    lsb_any  = 1'b0;
    word_any = 1'b0;
    for (int i = 0; i < LFSR_LENGTH; i++) begin
      lsb_any  = lsb_any | s_q[i][0];
      word_any = word_any | (|s_q[i]);
    end
    if (mode) fb = s_q[LFSR_LENGTH-1] ^ s_q[LFSR_FEEDBACK-1];
    else      fb = s_q[LFSR_LENGTH-1] + s_q[LFSR_FEEDBACK-1];
    if (mode ? !word_any : !lsb_any) fb[0] = 1'b1;
    s_step[0] = fb;
    for (int i = 1; i < LFSR_LENGTH; i++) s_step[i] = s_q[i-1];
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    v_d     = v_q;
    err_d   = 1'b0;
    save_en = 1'b0;
    if (init_rise) begin
      for (int i = 0; i < LFSR_LENGTH; i++) s_d[i] = '0;
      s_d[0]  = seed | OUT_SIZE'(1);
      cnt_d   = CNT_W'(WARMUP);
      state_d = (WARMUP == 0) ? READY : WARM;
    end else begin
      unique case (state_q)
        IDLE: err_d = cmd;
        WARM: begin
          err_d = cmd;
          s_d   = s_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = READY;
        end
        READY: begin
          if (restore) begin
            if (v_q[slot]) s_d = c_q[slot];
            else           err_d = 1'b1;
          end else begin
            if (save) begin
              save_en   = 1'b1;
              v_d[slot] = 1'b1;
            end
            if (next) s_d = s_step;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      init_q  <= 1'b0;
      err_q   <= 1'b0;
      v_q     <= '0;
      for (int i = 0; i < LFSR_LENGTH; i++)
        s_q[i] <= (i == 0) ? OUT_SIZE'(1) : '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= init;
      err_q   <= err_d;
      v_q     <= v_d;
      s_q     <= s_d;
    end
  end

  // NOTE: checkpoint storage is not reset; the valid bits alone decide
  // whether a slot may be restored, which keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (save_en) c_q[slot] <= s_q;
  end

  assign out   = s_q[0];
  assign ready = (state_q == READY);
  assign err   = err_q;

endmodule

// File: tb/tb_rnd_vec_gen_mc.sv
// Scoreboard bench: drivers push expected outputs, a monitor compares them
// at the falling edge (or immediately on demand during async reset).
module tb_rnd_vec_gen_mc;

  typedef struct {
    string       name;
    int          unit;
    logic [15:0] eo;
    logic        er;
    logic        ee;
    logic [2:0]  m;
  } exp_t;

  localparam logic [2:0] M_OUT = 3'b001, M_RDY = 3'b010, M_ERR = 3'b100;
  localparam logic [2:0] M_ALL = 3'b111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, init, mode, next, save, restore, slot;
  logic [15:0] seed;
  logic [7:0]  out0, out1;
  logic [15:0] out2;
  logic        rdy0, rdy1, rdy2, err0, err1, err2;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  event check_ev;

  logic [15:0] md [55];
  logic [15:0] mc [55];

  rnd_vec_gen_mc #(.OUT_SIZE(8), .LFSR_LENGTH(3), .LFSR_FEEDBACK(2), .SLOT_W(1), .WARMUP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .init(init), .seed(seed[7:0]), .mode(mode), .next(next),
    .save(save), .restore(restore), .slot(slot), .out(out0), .ready(rdy0), .err(err0));

  rnd_vec_gen_mc #(.OUT_SIZE(8), .LFSR_LENGTH(3), .LFSR_FEEDBACK(2), .SLOT_W(1), .WARMUP(4)) u1 (
    .clk(clk), .rst_n(rst_n), .init(init), .seed(seed[7:0]), .mode(mode), .next(next),
    .save(save), .restore(restore), .slot(slot), .out(out1), .ready(rdy1), .err(err1));

  rnd_vec_gen_mc u2 (
    .clk(clk), .rst_n(rst_n), .init(init), .seed(seed), .mode(mode), .next(next),
    .save(save), .restore(restore), .slot(slot), .out(out2), .ready(rdy2), .err(err2));

  always begin : monitor
    exp_t        e;
    logic [15:0] ao;
    logic        ar, ae;
    @(negedge clk or check_ev);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.unit)
        0:       begin ao = {8'h00, out0}; ar = rdy0; ae = err0; end
        1:       begin ao = {8'h00, out1}; ar = rdy1; ae = err1; end
        default: begin ao = out2;          ar = rdy2; ae = err2; end
      endcase
      if (e.m[0]) begin
        checks++;
        if (ao !== e.eo) begin
          errors++;
          $display("FAIL %s: out=%h expected %h", e.name, ao, e.eo);
        end
      end
      if (e.m[1]) begin
        checks++;
        if (ar !== e.er) begin
          errors++;
          $display("FAIL %s: ready=%b expected %b", e.name, ar, e.er);
        end
      end
      if (e.m[2]) begin
        checks++;
        if (ae !== e.ee) begin
          errors++;
          $display("FAIL %s: err=%b expected %b", e.name, ae, e.ee);
        end
      end
    end
  end

  task automatic push(input string nm, input int u, input logic [15:0] eo,
                      input logic er, input logic ee, input logic [2:0] m);
    exp_t e;
    e.name = nm; e.unit = u; e.eo = eo; e.er = er; e.ee = ee; e.m = m;
    sb.push_back(e);
  endtask

  // One clock edge with the currently driven strobes, then clear them.
  task automatic tick(input string nm, input int u, input logic [15:0] eo,
                      input logic er, input logic ee, input logic [2:0] m);
    @(posedge clk);
    if (m != 3'b000) push(nm, u, eo, er, ee, m);
    @(negedge clk);
    init = 1'b0; next = 1'b0; save = 1'b0; restore = 1'b0;
  endtask

  task automatic check_now(input string nm, input int u, input logic [15:0] eo,
                           input logic er, input logic ee);
    #1;
    push(nm, u, eo, er, ee, M_ALL);
    -> check_ev;
    #1;
  endtask

  // Guarantees a low cycle on init before raising it again.
  task automatic start_init(input logic [15:0] s);
    tick("idle", 0, 16'h0, 1'b0, 1'b0, 3'b000);
    seed = s;
    init = 1'b1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    check_now("rst_u0", 0, 16'h0001, 1'b0, 1'b0);
    check_now("rst_u1", 1, 16'h0001, 1'b0, 1'b0);
    check_now("rst_u2", 2, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic model_seed(input logic [15:0] s);
    for (int i = 0; i < 55; i++) md[i] = 16'h0000;
    md[0] = {s[15:1], 1'b1};
  endtask

  task automatic model_step(input logic m);
    logic [15:0] nw;
    logic        any_lsb, any_word;
    any_lsb = 1'b0; any_word = 1'b0;
    for (int i = 0; i < 55; i++) begin
      any_lsb  = any_lsb | md[i][0];
      any_word = any_word | (md[i] != 16'h0000);
    end
    nw = m ? (md[54] ^ md[23]) : (md[54] + md[23]);
    if (m ? !any_word : !any_lsb) nw[0] = 1'b1;
    for (int i = 54; i > 0; i--) md[i] = md[i-1];
    md[0] = nw;
  endtask

  logic [7:0] seq_add [5] = '{8'h00, 8'h05, 8'h05, 8'h05, 8'h0A};
  logic [7:0] seq_xor [5] = '{8'h00, 8'h05, 8'h05, 8'h05, 8'h00};
  logic [7:0] seq_pre [3] = '{8'h05, 8'h05, 8'h0A};
  logic [7:0] seq_warm[4] = '{8'h00, 8'h05, 8'h05, 8'h05};

  initial begin
    rst_n = 1'b0; init = 1'b0; mode = 1'b0; next = 1'b0; save = 1'b0;
    restore = 1'b0; slot = 1'b0; seed = 16'h0000;
    @(negedge clk);
    check_now("rst_u0", 0, 16'h0001, 1'b0, 1'b0);
    check_now("rst_u2", 2, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Seed handling: lsb forced to 1, ready immediately with no warm-up.
    start_init(16'h0004);
    tick("init_04", 0, 16'h0005, 1'b1, 1'b0, M_ALL);

    // Additive recurrence.
    mode = 1'b0;
    start_init(16'h0005);
    tick("add_seed", 0, 16'h0005, 1'b1, 1'b0, M_ALL);
    for (int i = 0; i < 5; i++) begin
      next = 1'b1;
      tick("add_step", 0, {8'h00, seq_add[i]}, 1'b1, 1'b0, M_ALL);
    end

    // XOR recurrence.
    mode = 1'b1;
    start_init(16'h0005);
    tick("xor_seed", 0, 16'h0005, 1'b1, 1'b0, M_ALL);
    for (int i = 0; i < 5; i++) begin
      next = 1'b1;
      tick("xor_step", 0, {8'h00, seq_xor[i]}, 1'b1, 1'b0, M_ALL);
    end

    // Save together with next captures pre-step state; restore replays it.
    mode = 1'b0;
    start_init(16'h0005);
    tick("cp_seed", 0, 16'h0005, 1'b1, 1'b0, M_ALL);
    next = 1'b1; tick("cp_n1", 0, 16'h0000, 1'b1, 1'b0, M_ALL);
    next = 1'b1; tick("cp_n2", 0, 16'h0005, 1'b1, 1'b0, M_ALL);
    slot = 1'b1; save = 1'b1; next = 1'b1;
    tick("cp_save", 0, 16'h0005, 1'b1, 1'b0, M_ALL);
    next = 1'b1; tick("cp_n3", 0, 16'h0005, 1'b1, 1'b0, M_ALL);
    next = 1'b1; tick("cp_n4", 0, 16'h000A, 1'b1, 1'b0, M_ALL);
    next = 1'b1; tick("cp_n5", 0, 16'h000A, 1'b1, 1'b0, M_ALL);
    restore = 1'b1; tick("cp_restore", 0, 16'h0005, 1'b1, 1'b0, M_ALL);
    for (int i = 0; i < 3; i++) begin
      next = 1'b1;
      tick("cp_replay", 0, {8'h00, seq_pre[i]}, 1'b1, 1'b0, M_ALL);
    end

    // Restore of a never-saved slot after reset.
    @(negedge clk);
    do_reset();
    start_init(16'h0004);
    tick("inv_init", 0, 16'h0005, 1'b1, 1'b0, M_ALL);
    slot = 1'b0; restore = 1'b1;
    tick("inv_restore", 0, 16'h0005, 1'b1, 1'b1, M_ALL);
    tick("inv_err_clr", 0, 16'h0005, 1'b1, 1'b0, M_ALL);

    // Warm-up of 4: command while not ready errs, ready on the 4th edge.
    do_reset();
    start_init(16'h0004);
    tick("wu_init", 1, 16'h0005, 1'b0, 1'b0, M_ALL);
    next = 1'b1;
    tick("wu_e1", 1, {8'h00, seq_warm[0]}, 1'b0, 1'b1, M_ALL);
    tick("wu_e2", 1, {8'h00, seq_warm[1]}, 1'b0, 1'b0, M_ALL);
    tick("wu_e3", 1, {8'h00, seq_warm[2]}, 1'b0, 1'b0, M_ALL);
    tick("wu_e4", 1, {8'h00, seq_warm[3]}, 1'b1, 1'b0, M_ALL);

    // Default parameters: long run, checkpoint mid-stream, replay.
    mode = 1'b0;
    start_init(16'h1234);
    model_seed(16'h1234);
    tick("big_init", 2, md[0], 1'b0, 1'b0, M_ALL);
    for (int i = 1; i <= 64; i++) begin
      model_step(1'b0);
      tick("big_warm", 2, md[0], (i == 64), 1'b0, M_ALL);
    end
    for (int i = 0; i < 5000; i++) begin
      next = 1'b1; model_step(1'b0);
      tick("big_run", 2, md[0], 1'b1, 1'b0, M_ALL);
    end
    mc = md;
    slot = 1'b0; save = 1'b1; next = 1'b1; model_step(1'b0);
    tick("big_save", 2, md[0], 1'b1, 1'b0, M_ALL);
    for (int i = 0; i < 4999; i++) begin
      next = 1'b1; model_step(1'b0);
      tick("big_run2", 2, md[0], 1'b1, 1'b0, M_ALL);
    end
    md = mc;
    restore = 1'b1;
    tick("big_restore", 2, md[0], 1'b1, 1'b0, M_ALL);
    for (int i = 0; i < 5000; i++) begin
      next = 1'b1; model_step(1'b0);
      tick("big_replay", 2, md[0], 1'b1, 1'b0, M_ALL);
    end

    // Reset in the middle of warm-up clears valid bits.
    start_init(16'h1234);
    tick("mw_init", 2, 16'h1235, 1'b0, 1'b0, M_ALL);
    for (int i = 0; i < 10; i++) tick("mw_warm", 2, 16'h0, 1'b0, 1'b0, M_RDY);
    do_reset();
    start_init(16'h00FF);
    for (int i = 0; i <= 64; i++) tick("mw_rewarm", 2, 16'h0, (i == 64), 1'b0, M_RDY);
    slot = 1'b0; restore = 1'b1;
    tick("mw_v_clr", 2, 16'h0, 1'b1, 1'b1, M_RDY | M_ERR);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: pending=%0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
